syn_s_info: RTL and testbench



---
 rtl/syn_s_info.sv | 217 +++++++++++++++++++++
 tb/tb_syn_s_info.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_s_info.sv
// syn_s_info: slave-side receiver for the UTC-seconds info link.
// Each frame is four 8N1 characters sent MSB byte first on rx_info. When
// the fourth character arrives, the frame is published as utc_sec with a
// one-cycle info_vld strobe. A low stop bit or an inter-byte timeout drops
// the partial frame and raises a one-cycle error pulse.
module syn_s_info #(
   parameter logic [19:0] TBIT_PERIOD = 20'd1000,
   parameter logic [19:0] TOUT_PERIOD = 20'd20000
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        rx_info,
   output logic [31:0] utc_sec,
   output logic        info_vld,
   output logic        err_frame,
   output logic        err_tout
);

   localparam logic [19:0] HALF_M1 = (TBIT_PERIOD >> 1) - 20'd1;
   localparam logic [19:0] FULL_M1 = TBIT_PERIOD - 20'd1;
   localparam logic [19:0] TOUT_M1 = TOUT_PERIOD - 20'd1;

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_st_t;
   // The state name is the number of bytes of the current frame held so far.
   typedef enum logic [1:0] {S_IDLE, S_B1, S_B2, S_B3} byte_st_t;

   logic        rx_s1, rx_s2, rx_s3;
   logic        rx_fall;

   bit_st_t     bit_st, bit_nxt;
   logic [19:0] bit_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  rx_byte;
   logic        cnt_clr;
   logic        shift_en;
   logic        byte_ok;
   logic        stop_bad;

   byte_st_t    byte_st, byte_nxt;
   logic [23:0] asm_p0;
   logic [19:0] tout_cnt;
   logic        tout_hit;
   logic        frame_done;

   // ---- stage: input synchronizer and edge detect ----
   // Two flops for metastability plus a third so a falling edge can be seen;
   // all reset high so an idle line never looks like a start bit.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= rx_info;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   assign rx_fall = rx_s3 & ~rx_s2;

   // ---- stage: bit recovery ----
   // Bit FSM state register.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         bit_st <= B_IDLE;
      end else begin
         bit_st <= bit_nxt;
      end
   end

   // Bit FSM next state: sample mid-bit, leave B_STOP straight to B_IDLE so a
   // back-to-back start edge half a bit later is not missed.
   always_comb begin
      bit_nxt  = bit_st;
      cnt_clr  = 1'b0;
      shift_en = 1'b0;
      byte_ok  = 1'b0;
      stop_bad = 1'b0;
      case (bit_st)
         B_IDLE: begin
            if (rx_fall) begin
               bit_nxt = B_START;
               cnt_clr = 1'b1;
            end
         end
         B_START: begin
            if (bit_cnt == HALF_M1) begin
               cnt_clr = 1'b1;
               // A start bit that is high again mid-bit was only a glitch.
               bit_nxt = rx_s2 ? B_IDLE : B_DATA;
            end
         end
         B_DATA: begin
            if (bit_cnt == FULL_M1) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_idx == 3'd7) begin
                  bit_nxt = B_STOP;
               end
            end
         end
         B_STOP: begin
            if (bit_cnt == FULL_M1) begin
               cnt_clr = 1'b1;
               bit_nxt = B_IDLE;
               if (rx_s2) begin
                  byte_ok = 1'b1;
               end else begin
                  stop_bad = 1'b1;
               end
            end
         end
         default: begin
            bit_nxt = B_IDLE;
         end
      endcase
   end

   // Bit timing counter and bit index; the index restarts at every start bit.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         bit_cnt <= 20'd0;
         bit_idx <= 3'd0;
      end else begin
         if (cnt_clr) begin
            bit_cnt <= 20'd0;
         end else if (bit_st != B_IDLE) begin
            bit_cnt <= bit_cnt + 20'd1;
         end
         if (bit_st == B_START) begin
            bit_idx <= 3'd0;
         end else if (shift_en) begin
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   // Character shift register, LSB arrives first.
   always_ff @(posedge clk_sys) begin
      if (shift_en) begin
         rx_byte <= {rx_s2, rx_byte[7:1]};
      end
   end

   // ---- stage: frame assembly and timeout ----
   // A completed byte outranks a timeout landing on the same cycle.
   assign tout_hit = (byte_st != S_IDLE) && (tout_cnt == TOUT_M1) && !byte_ok && !stop_bad;

   // Byte FSM state register.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         byte_st <= S_IDLE;
      end else begin
         byte_st <= byte_nxt;
      end
   end

   // Byte FSM next state: count bytes held, publish on the fourth.
   always_comb begin
      byte_nxt   = byte_st;
      frame_done = 1'b0;
      if (stop_bad || tout_hit) begin
         byte_nxt = S_IDLE;
      end else if (byte_ok) begin
         case (byte_st)
            S_IDLE:  byte_nxt = S_B1;
            S_B1:    byte_nxt = S_B2;
            S_B2:    byte_nxt = S_B3;
            default: begin
               byte_nxt   = S_IDLE;
               frame_done = 1'b1;
            end
         endcase
      end
   end

   // Assembly register keeps the three most recent bytes of the frame; the
   // fourth is taken directly from the shift register when publishing.
   always_ff @(posedge clk_sys) begin
      if (stop_bad || tout_hit) begin
         asm_p0 <= 24'd0;
      end else if (byte_ok) begin
         asm_p0 <= {asm_p0[15:0], rx_byte};
      end
   end

   // Inter-byte timeout: runs only while a frame is partially assembled.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         tout_cnt <= 20'd0;
      end else if ((byte_st == S_IDLE) || byte_ok || stop_bad || tout_hit) begin
         tout_cnt <= 20'd0;
      end else begin
         tout_cnt <= tout_cnt + 20'd1;
      end
   end

   // ---- stage: registered outputs ----
   // utc_sec holds between frames and is untouched by errors.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         utc_sec   <= 32'h0;
         info_vld  <= 1'b0;
         err_frame <= 1'b0;
         err_tout  <= 1'b0;
      end else begin
         info_vld  <= frame_done;
         err_frame <= stop_bad;
         err_tout  <= tout_hit;
         if (frame_done) begin
            utc_sec <= {asm_p0, rx_byte};
         end
      end
   end

endmodule

// File: tb/tb_syn_s_info.sv
// tb_syn_s_info: drives 8N1 characters onto rx_info and checks syn_s_info
// every cycle against a character-level model of frames, errors and timeouts.
module tb_syn_s_info;

   localparam int T    = 10;
   localparam int H    = T / 2;
   localparam int TOUT = 200;
   // Clocks from the driven start-bit edge to the registered stop result:
   // 2 sync flops + edge flop, half a bit for start, 9 full bits to stop.
   localparam int LAT  = 3 + H + 9 * T;

   logic        clk_sys = 1'b0;
   logic        rst     = 1'b1;
   logic        rx_info = 1'b1;
   logic [31:0] utc_sec;
   logic        info_vld;
   logic        err_frame;
   logic        err_tout;

   syn_s_info #(
      .TBIT_PERIOD(20'd10),
      .TOUT_PERIOD(20'd200)
   ) dut (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .rx_info  (rx_info),
      .utc_sec  (utc_sec),
      .info_vld (info_vld),
      .err_frame(err_frame),
      .err_tout (err_tout)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      int         at;
      logic [7:0] b;
      bit         ok;
   } ev_t;

   ev_t ev_q[$];
   ev_t ev;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   // character-level model
   logic [31:0] m_utc;
   logic [31:0] m_asm;
   bit          m_vld, m_ferr, m_tout;
   int          m_nb;
   int          m_last;

   // observed DUT pulse counts
   int c_vld = 0, c_ferr = 0, c_tout = 0;
   int last_tout_cyc = -1;
   int b_vld, b_ferr, b_tout;
   int k_start;

   // Model update on each clock edge, then compare all outputs 1 time unit later.
   initial begin
      m_utc = 32'h0; m_asm = 32'h0; m_nb = 0; m_last = 0;
      m_vld = 1'b0; m_ferr = 1'b0; m_tout = 1'b0;
      forever begin
         @(posedge clk_sys);
         cyc++;
         if (rst) begin
            m_utc = 32'h0; m_asm = 32'h0; m_nb = 0;
            m_vld = 1'b0; m_ferr = 1'b0; m_tout = 1'b0;
            ev_q.delete();
         end else begin
            m_vld = 1'b0; m_ferr = 1'b0; m_tout = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
               ev = ev_q.pop_front();
               if (ev.ok) begin
                  m_last = cyc;
                  if (m_nb == 3) begin
                     m_utc = {m_asm[23:0], ev.b};
                     m_vld = 1'b1;
                     m_nb  = 0;
                  end else begin
                     m_asm = {m_asm[23:0], ev.b};
                     m_nb  = m_nb + 1;
                  end
               end else begin
                  m_ferr = 1'b1;
                  m_nb   = 0;
               end
            end else if (m_nb > 0 && cyc == m_last + TOUT) begin
               m_tout = 1'b1;
               m_nb   = 0;
            end
         end
         #1;
         n_chk++;
         if ({utc_sec, info_vld, err_frame, err_tout} === {m_utc, m_vld, m_ferr, m_tout}) begin
            n_pass++;
         end else begin
            $display("FAIL cycle_%0d: utc=%h vld=%b ferr=%b tout=%b, required utc=%h vld=%b ferr=%b tout=%b",
                     cyc, utc_sec, info_vld, err_frame, err_tout, m_utc, m_vld, m_ferr, m_tout);
         end
         if (info_vld === 1'b1) c_vld++;
         if (err_frame === 1'b1) c_ferr++;
         if (err_tout === 1'b1) begin
            c_tout++;
            last_tout_cyc = cyc;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic snap();
      b_vld = c_vld; b_ferr = c_ferr; b_tout = c_tout;
   endtask

   task automatic check_counts(input string name, input int dv, input int df, input int dt);
      check({name, "_vld"},  32'(c_vld - b_vld),   32'(dv));
      check({name, "_ferr"}, 32'(c_ferr - b_ferr), 32'(df));
      check({name, "_tout"}, 32'(c_tout - b_tout), 32'(dt));
   endtask

   // Called at a negedge; drives one character and then `gap` idle clocks.
   task automatic send_char(input logic [7:0] b, input bit ok, input int gap);
      ev_t        e;
      logic [9:0] bits;
      bits    = {ok, b, 1'b0};
      k_start = cyc;
      e.at = cyc + LAT;
      e.b  = b;
      e.ok = ok;
      ev_q.push_back(e);
      for (int j = 0; j < 10; j++) begin
         rx_info = bits[j];
         repeat (T) @(negedge clk_sys);
      end
      rx_info = 1'b1;
      repeat (gap) @(negedge clk_sys);
   endtask

   task automatic send_frame(input logic [31:0] w, input int gap);
      send_char(w[31:24], 1'b1, 0);
      send_char(w[23:16], 1'b1, 0);
      send_char(w[15:8],  1'b1, 0);
      send_char(w[7:0],   1'b1, gap);
   endtask

   task automatic idle(input int n);
      rx_info = 1'b1;
      repeat (n) @(negedge clk_sys);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
      $fatal(1, "time limit");
   end

   initial begin
      int k_ad;
      int gap;
      bit ok;
      logic [7:0] b;

      // reset with idle line
      rst = 1'b1;
      rx_info = 1'b1;
      repeat (5) @(negedge clk_sys);
      rst = 1'b0;
      snap();
      idle(500);
      check_counts("reset", 0, 0, 0);
      check("reset_utc", utc_sec, 32'h0);

      // single frames, back to back characters
      snap();
      send_frame(32'h12345678, 20);
      check_counts("frame1", 1, 0, 0);
      check("frame1_utc", utc_sec, 32'h12345678);
      check("frame1_model", m_utc, 32'h12345678);
      send_frame(32'h12345679, 20);
      check("frame2_utc", utc_sec, 32'h12345679);

      // framing error on the third character
      snap();
      send_char(8'hAA, 1'b1, 0);
      send_char(8'hBB, 1'b1, 0);
      send_char(8'h5C, 1'b0, 20);
      idle(50);
      check_counts("ferr", 0, 1, 0);
      check("ferr_utc_held", utc_sec, 32'h12345679);
      send_frame(32'h00000001, 20);
      check("after_ferr_utc", utc_sec, 32'h00000001);

      // inter-byte timeout
      snap();
      send_char(8'hDE, 1'b1, 0);
      send_char(8'hAD, 1'b1, 300);
      k_ad = k_start;
      check_counts("tout", 0, 0, 1);
      check("tout_cycle", 32'(last_tout_cyc), 32'(k_ad + 98 + 200));
      send_frame(32'hCAFEF00D, 20);
      check("after_tout_utc", utc_sec, 32'hCAFEF00D);

      // glitch on idle line
      snap();
      rx_info = 1'b0;
      repeat (3) @(negedge clk_sys);
      idle(50);
      check_counts("glitch", 0, 0, 0);
      send_frame(32'hA5C30F96, 20);
      check("after_glitch_utc", utc_sec, 32'hA5C30F96);

      // reset in the middle of byte 3
      send_char(8'h00, 1'b1, 0);
      send_char(8'h00, 1'b1, 0);
      rx_info = 1'b0;
      repeat (T) @(negedge clk_sys);
      rx_info = 1'b1;
      repeat (2 * T) @(negedge clk_sys);
      rx_info = 1'b0;
      repeat (T + 3) @(negedge clk_sys);
      rst = 1'b1;
      rx_info = 1'b1;
      repeat (5) @(negedge clk_sys);
      rst = 1'b0;
      check("midrst_utc", utc_sec, 32'h0);
      idle(3 * T);
      snap();
      send_frame(32'h00000010, 20);
      check_counts("midrst", 1, 0, 0);
      check("midrst_utc_frame", utc_sec, 32'h00000010);

      // timeout boundary: byte landing exactly on the limit wins
      snap();
      send_char(8'h11, 1'b1, 0);
      send_char(8'h22, 1'b1, 100);
      send_char(8'h33, 1'b1, 0);
      send_char(8'h44, 1'b1, 20);
      check_counts("tout_edge", 1, 0, 0);
      check("tout_edge_utc", utc_sec, 32'h11223344);
      // one clock later the timeout fires first
      snap();
      send_char(8'h55, 1'b1, 0);
      send_char(8'h66, 1'b1, 101);
      send_char(8'h77, 1'b1, 0);
      send_char(8'h88, 1'b1, 300);
      check_counts("tout_late", 0, 0, 2);
      check("tout_late_utc", utc_sec, 32'h11223344);

      // randomized traffic against the model
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < 4; i++) begin
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 15) != 0);
            gap = $urandom_range(0, 9);
            if (gap < 6) gap = 0;
            else if (gap < 9) gap = $urandom_range(1, 30);
            else gap = $urandom_range(150, 260);
            if (!ok && gap < T) gap = T;
            send_char(b, ok, gap);
         end
      end
      idle(300);
      check("events_drained", 32'(ev_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
